// File: rtl/shape_pkg.sv
// Shared definitions for the shape configuration SFR master.
// Holds the field types, SFR bit positions, SFR reset values, the master
// FSM state encoding and the legality rules for shape/operation values.
package shape_pkg;

    typedef logic [1:0] shape_t;
    typedef logic [4:0] operation_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        CHECK,
        RESP
    } state_t;

    // SFR word layout: shape in [17:16], operation in [4:0], rest reserved.
    localparam int          SHAPE_LSB  = 16;
    localparam int          SHAPE_W    = 2;
    localparam int          OP_LSB     = 0;
    localparam int          OP_W       = 5;
    localparam logic [31:0] FIELD_MASK = 32'h0003_001F;

    // SFR contents out of reset.
    localparam shape_t     SHAPE_RST = 2'b01;
    localparam operation_t OP_RST    = 5'b00000;

    // Command encodings that ask to update only one of the two fields.
    localparam shape_t     SHAPE_KEEP = 2'b00;
    localparam operation_t OP_KEEP    = 5'b11111;

    // A shape is legal only when exactly one bit is set.
    function automatic logic is_legal_shape(input shape_t shape);
        return (shape == 2'b01) || (shape == 2'b10);
    endfunction

    // op[4:3] selects a class; each class allows a few sub-codes in op[2:0].
    function automatic logic is_legal_operation(input operation_t op);
        logic ok;
        case (op[4:3])
            2'b00:   ok = (op[2:0] <= 3'd1);
            2'b01:   ok = (op[2:0] == 3'd0);
            2'b10:   ok = (op[2:0] <= 3'd1);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Class 00 operations work with any shape; other classes need the
    // shape whose code equals the class.
    function automatic logic is_legal_combination(input shape_t shape, input operation_t op);
        return (op[4:3] == 2'b00) || (op[4:3] == shape);
    endfunction

    function automatic logic [31:0] pack_sfr(input shape_t shape, input operation_t op);
        logic [31:0] word;
        word                       = '0;
        word[SHAPE_LSB +: SHAPE_W] = shape;
        word[OP_LSB +: OP_W]       = op;
        return word;
    endfunction

endpackage

// File: rtl/shape_sfr_predictor.sv
// Predicts the SFR contents after a write, given the current mirror of the
// SFR and the requested command. Purely combinational.
//   mirror_shape/mirror_operation : last known SFR contents
//   cmd_shape/cmd_operation       : fields being written
//   pred_shape/pred_operation     : contents the SFR should hold afterwards
module shape_sfr_predictor
    import shape_pkg::*;
(
    input  logic [1:0] mirror_shape,
    input  logic [4:0] mirror_operation,
    input  logic [1:0] cmd_shape,
    input  logic [4:0] cmd_operation,
    output logic [1:0] pred_shape,
    output logic [4:0] pred_operation
);

    // NOTE: every output gets a default before any branch, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        pred_shape     = mirror_shape;
        pred_operation = mirror_operation;
        if (is_legal_shape(cmd_shape) && is_legal_operation(cmd_operation)
            && is_legal_combination(cmd_shape, cmd_operation)) begin
            pred_shape     = cmd_shape;
            pred_operation = cmd_operation;
        end else if (cmd_shape == SHAPE_KEEP && is_legal_operation(cmd_operation)
                     && is_legal_combination(mirror_shape, cmd_operation)) begin
            // Operation-only update, checked against the shape already held.
            pred_operation = cmd_operation;
        end else if (cmd_operation == OP_KEEP && is_legal_shape(cmd_shape)
                     && is_legal_combination(cmd_shape, mirror_operation)) begin
            // Shape-only update, checked against the operation already held.
            pred_shape = cmd_shape;
        end
    end

endmodule

// File: rtl/shape_cfg_master.sv
// Shape configuration master: accepts a command, writes it to the SFR,
// reads the SFR back after READ_LATENCY cycles, compares against the
// predicted contents and returns the read-back with a match flag.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   cmd_valid/ready/shape/operation : command handshake and fields
//   write, write_data           : one-cycle SFR write strobe and word
//   read, read_data             : one-cycle SFR read strobe and returned word
//   rsp_valid/ready/match/shape/operation : response handshake and payload
//   error                       : sticky mismatch flag, cleared only by reset
module shape_cfg_master
    import shape_pkg::*;
#(
    parameter int READ_LATENCY = 1,    // legal range 1..4
    parameter bit CHECK_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_shape,
    input  logic [4:0]  cmd_operation,
    output logic        write,
    output logic [31:0] write_data,
    output logic        read,
    input  logic [31:0] read_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_match,
    output logic [1:0]  rsp_shape,
    output logic [4:0]  rsp_operation,
    output logic        error
);

    state_t     state, state_nx;
    shape_t     cmd_shape_q, mirror_shape_q, pred_shape_q, pred_shape;
    operation_t cmd_op_q, mirror_op_q, pred_op_q, pred_op;
    logic [2:0] lat_cnt;
    logic [31:0] sample_q;
    logic       sample_match;

    shape_sfr_predictor u_predictor (
        .mirror_shape     (mirror_shape_q),
        .mirror_operation (mirror_op_q),
        .cmd_shape        (cmd_shape_q),
        .cmd_operation    (cmd_op_q),
        .pred_shape       (pred_shape),
        .pred_operation   (pred_op)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = WRITE;
            end
            WRITE: begin
                write    = 1'b1;
                state_nx = READ;
            end
            READ: begin
                read     = 1'b1;
                state_nx = WAIT;
            end
            WAIT:    if (lat_cnt == 3'd0) state_nx = CHECK;
            CHECK:   state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The write word is driven only while the strobe is up.
    always_comb begin
        write_data = '0;
        if (state == WRITE) write_data = pack_sfr(cmd_shape_q, cmd_op_q);
    end

    // Reserved read-back bits must be zero as well as the fields matching.
    always_comb begin
        sample_match = 1'b1;
        if (CHECK_EN) begin
            sample_match = (sample_q[SHAPE_LSB +: SHAPE_W] == pred_shape_q)
                        && (sample_q[OP_LSB +: OP_W] == pred_op_q)
                        && ((sample_q & ~FIELD_MASK) == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_shape_q    <= '0;
            cmd_op_q       <= '0;
            pred_shape_q   <= SHAPE_RST;
            pred_op_q      <= OP_RST;
            mirror_shape_q <= SHAPE_RST;
            mirror_op_q    <= OP_RST;
            lat_cnt        <= '0;
            sample_q       <= '0;
            rsp_match      <= 1'b0;
            rsp_shape      <= '0;
            rsp_operation  <= '0;
            error          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    cmd_shape_q <= cmd_shape;
                    cmd_op_q    <= cmd_operation;
                end
                WRITE: begin
                    pred_shape_q <= pred_shape;
                    pred_op_q    <= pred_op;
                end
                READ: lat_cnt <= 3'(READ_LATENCY);
                // The counter sits at zero for one cycle; that is the
                // cycle whose read_data is captured.
                WAIT: begin
                    if (lat_cnt == 3'd0) sample_q <= read_data;
                    else                 lat_cnt  <= lat_cnt - 3'd1;
                end
                CHECK: begin
                    rsp_match      <= sample_match;
                    rsp_shape      <= sample_q[SHAPE_LSB +: SHAPE_W];
                    rsp_operation  <= sample_q[OP_LSB +: OP_W];
                    // The mirror follows what the SFR actually holds,
                    // even when it disagrees with the prediction.
                    mirror_shape_q <= sample_q[SHAPE_LSB +: SHAPE_W];
                    mirror_op_q    <= sample_q[OP_LSB +: OP_W];
                    if (!sample_match) error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/shape_cfg_master.md
SHAPE_CFG_MASTER -- requirements
Module: shape_cfg_master

Interface
REQ-001 Parameter READ_LATENCY, default 1, cycles from read pulse to valid read_data, legal range 1..4.
REQ-002 Parameter CHECK_EN, default 1, when 0 the compare result is forced to match and error never sets.
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 cmd_shape  input  2  requested shape field.
REQ-008 cmd_operation  input  5  requested operation field.
REQ-009 write  output  1  one-cycle SFR write strobe.
REQ-010 write_data  output  32  SFR write word: [17:16] shape, [4:0] operation, all other bits 0.
REQ-011 read  output  1  one-cycle SFR read strobe.
REQ-012 read_data  input  32  SFR read word, same field layout as write_data.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-015 rsp_match  output  1  read-back equalled prediction.
REQ-016 rsp_shape  output  2  read-back shape field.
REQ-017 rsp_operation  output  5  read-back operation field.
REQ-018 error  output  1  sticky mismatch flag.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, READ, WAIT, CHECK, RESP.
REQ-020 IDLE: cmd_ready=1; cmd_valid&cmd_ready latches cmd fields, goes to WRITE.
REQ-021 cmd_ready SHALL be 0 in every state except IDLE.
REQ-022 WRITE: write=1 for exactly one cycle with latched fields; prediction computed from mirror and latched command; next READ.
REQ-023 READ: read=1 for exactly one cycle; latency counter loaded with READ_LATENCY; next WAIT.
REQ-024 WAIT: counter decrements each cycle; read_data sampled on the cycle the counter reaches 0; next CHECK.
REQ-025 Prediction: legal combined data (onehot shape, legal operation, legal combination) -> both fields from command; else operation updated only if cmd_shape==0, operation legal and combination with mirror shape legal; else shape updated only if cmd_operation==5'b11111, shape onehot and combination with mirror operation legal; otherwise mirror unchanged.
REQ-026 Legal operation: op[4:3]==00 with op[2:0] in {0,1}, 01 with op[2:0]==0, 10 with op[2:0] in {0,1}; op[4:3]==11 illegal.
REQ-027 Legal combination: op[4:3]==00, or op[4:3] equals shape.
REQ-028 CHECK: match = sampled fields equal prediction and sampled reserved bits all 0; mismatch with CHECK_EN=1 sets error; next RESP.
REQ-029 CHECK SHALL load mirror with sampled fields (resynchronise) regardless of match.
REQ-030 RESP: rsp_valid=1, rsp_* held stable until rsp_ready; then IDLE in the following cycle.
REQ-031 Command-to-rsp_valid latency SHALL be 4+READ_LATENCY cycles from the accept edge.
REQ-032 write and read SHALL never be high in the same cycle.
REQ-033 error SHALL stay 1 until reset.

Reset
REQ-034 On rst_n low: state IDLE, write=0, read=0, write_data=0, rsp_valid=0, rsp_match=0, rsp_shape=0, rsp_operation=0, error=0, mirror shape=2'b01, mirror operation=5'b00000.
REQ-035 Reset mid-transaction SHALL abandon it without completing write, read or response.

Structure
REQ-036 Package shape_pkg SHALL hold shape/operation typedefs, field bit positions, SFR reset values and the is_legal_shape/operation/combination functions.
REQ-037 Sub-module shape_sfr_predictor SHALL implement REQ-025 combinationally (inputs mirror, command; output predicted fields).

Verification
REQ-038 After reset, cmd shape=01 op=01000 -> write_data=0x0001_0008, read-back 0x0001_0008 -> rsp_match=1, error=0.
REQ-039 Mirror 01/00000, cmd shape=11 op=00001 -> prediction unchanged 01/00000; read-back 0x0001_0001 -> rsp_match=0, error=1 and stays 1.
REQ-040 Mirror 10/00000, cmd shape=00 op=10001 -> predicted 10/10001; mirror 01/00000 same cmd -> predicted 01/00000.
REQ-041 READ_LATENCY=3, rsp_ready held low 5 cycles -> rsp_valid at accept+7, rsp fields stable, cmd_ready=0 throughout.
REQ-042 rst_n asserted during WAIT -> next cycle state IDLE, rsp_valid=0, mirror 01/00000, cmd_ready=1 after release.
